// File: rtl/router_if.sv
// Source-port and FIFO-side signal bundle of the 1x3 router ingress controller.
// master = source/FIFO environment, slave = router_ctrl.
interface router_if #(parameter int WIDTH = 8);
  logic             pkt_valid;
  logic [WIDTH-1:0] data_in;
  logic [2:0]       fifo_full;
  logic [2:0]       fifo_empty;
  logic [2:0]       read_enb;
  logic [2:0]       write_enb;
  logic [WIDTH-1:0] fifo_din;
  logic             lfd_state;
  logic             busy;
  logic             err;
  logic [2:0]       soft_reset;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
    input  write_enb, fifo_din, lfd_state, busy, err, soft_reset
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
    output write_enb, fifo_din, lfd_state, busy, err, soft_reset
  );
endinterface

// File: rtl/router_ctrl.sv
// 1x3 router ingress controller: header decode, byte steering into three FIFOs,
// length/parity checking and per-output stale-data timers that pulse soft_reset.
module router_ctrl #(
  parameter int TIMEOUT = 30,
  parameter int WIDTH   = 8
) (
  input  logic     clock,
  input  logic     reset,
  router_if.slave  bus
);

  localparam int LW = WIDTH - 2;

  localparam logic [2:0] DECODE = 3'd0;
  localparam logic [2:0] WAIT   = 3'd1;
  localparam logic [2:0] LFD    = 3'd2;
  localparam logic [2:0] LOAD   = 3'd3;
  localparam logic [2:0] CHECK  = 3'd4;
  localparam logic [2:0] DROP   = 3'd5;

  logic [2:0]       state, state_nxt;
  logic [1:0]       addr;
  logic [LW-1:0]    hdr_len, byte_cnt;
  logic [WIDTH-1:0] hold_reg, parity, rx_par;
  logic             err_q;
  logic [2:0]       sr_q;
  logic [2:0][4:0]  timer;

  logic [2:0]       wen;
  logic [WIDTH-1:0] din;
  logic             busy_c, lfd_c;

  logic [1:0]    in_addr;
  logic [LW-1:0] in_len;
  logic          hdr_ok, abort, full_cur;

  assign in_addr  = bus.data_in[1:0];
  assign in_len   = bus.data_in[WIDTH-1:2];
  assign hdr_ok   = (in_addr != 2'd3) && (in_len != '0);
  assign full_cur = bus.fifo_full[addr];
  // A timeout on our own target FIFO means it was flushed under us: abandon the packet.
  assign abort    = ((state == WAIT) || (state == LOAD)) && sr_q[addr];

  always_comb begin
    state_nxt = state;
    wen       = '0;
    din       = bus.data_in;
    busy_c    = 1'b0;
    lfd_c     = 1'b0;
    case (state)
      DECODE: begin
        if (bus.pkt_valid) begin
          if (hdr_ok) state_nxt = bus.fifo_empty[in_addr] ? LFD : WAIT;
          else        state_nxt = DROP;
        end
      end
      WAIT: begin
        busy_c = 1'b1;
        if (abort)                      state_nxt = bus.pkt_valid ? DROP : DECODE;
        else if (bus.fifo_empty[addr])  state_nxt = LFD;
      end
      LFD: begin
        busy_c    = 1'b1;
        lfd_c     = 1'b1;
        wen[addr] = 1'b1;
        din       = hold_reg;
        state_nxt = LOAD;
      end
      LOAD: begin
        busy_c = full_cur;
        if (abort) begin
          state_nxt = bus.pkt_valid ? DROP : DECODE;
        end else if (!full_cur) begin
          wen[addr] = 1'b1;
          if (!bus.pkt_valid) state_nxt = CHECK;
        end
      end
      CHECK: begin
        busy_c    = 1'b1;
        state_nxt = DECODE;
      end
      DROP: begin
        if (!bus.pkt_valid) state_nxt = DECODE;
      end
      default: state_nxt = DECODE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= DECODE;
      addr     <= '0;
      hdr_len  <= '0;
      byte_cnt <= '0;
      hold_reg <= '0;
      parity   <= '0;
      rx_par   <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        DECODE: begin
          if (bus.pkt_valid) begin
            if (hdr_ok) begin
              addr     <= in_addr;
              hdr_len  <= in_len;
              hold_reg <= bus.data_in;
              err_q    <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        WAIT: if (abort) err_q <= 1'b1;
        LFD: begin
          parity   <= hold_reg;
          byte_cnt <= '0;
        end
        LOAD: begin
          if (abort) begin
            err_q <= 1'b1;
          end else if (!full_cur) begin
            if (bus.pkt_valid) begin
              parity <= parity ^ bus.data_in;
              if (byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
            end else begin
              rx_par <= bus.data_in;
            end
          end
        end
        CHECK: err_q <= (rx_par != parity) || (byte_cnt != hdr_len);
        default: ;
      endcase
    end
  end

  // Stale-data timers, independent of the packet FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer <= '0;
      sr_q  <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (bus.fifo_empty[i] || bus.read_enb[i]) begin
          timer[i] <= '0;
          sr_q[i]  <= 1'b0;
        end else if (timer[i] == 5'(TIMEOUT - 1)) begin
          timer[i] <= '0;
          sr_q[i]  <= 1'b1;
        end else begin
          timer[i] <= timer[i] + 5'd1;
          sr_q[i]  <= 1'b0;
        end
      end
    end
  end

  assign bus.write_enb  = wen;
  assign bus.fifo_din   = din;
  assign bus.busy       = busy_c;
  assign bus.lfd_state  = lfd_c;
  assign bus.err        = err_q;
  assign bus.soft_reset = sr_q;

endmodule

// File: tb/tb_router_ctrl.sv
// Self-checking bench for router_ctrl: packet-level write/err model plus an
// idle-run-length model of the soft_reset timers, compared every cycle.
module tb_router_ctrl;
  localparam int TIMEOUT = 30;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  router_if #(.WIDTH(8)) bus ();

  router_ctrl #(.TIMEOUT(TIMEOUT), .WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [10:0] exp_q[$];   // {port[1:0], lfd, byte}
  logic [7:0]  pay [16];
  logic        err_at_lfd;
  int          run [3];
  logic [2:0]  exp_sr;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] calc_par(input logic [7:0] hdr, input int n);
    logic [7:0] p = hdr;
    for (int i = 0; i < n; i++) p ^= pay[i];
    return p;
  endfunction

  // Error rule for an accepted header: length field vs payload count, or parity mismatch.
  function automatic logic pkt_err(input logic [7:0] hdr, input int n, input logic [7:0] par);
    return (int'(hdr[7:2]) != n) || (calc_par(hdr, n) != par);
  endfunction

  task automatic expect_pkt(input logic [7:0] hdr, input int n, input logic [7:0] par, input int nwr);
    logic [7:0] b;
    for (int i = 0; i < nwr; i++) begin
      b = (i == 0) ? hdr : (i <= n) ? pay[i-1] : par;
      exp_q.push_back({hdr[1:0], (i == 0), b});
    end
  endtask

  task automatic set_pay(input logic [7:0] a, b, c, d, e);
    pay[0] = a; pay[1] = b; pay[2] = c; pay[3] = d; pay[4] = e;
  endtask

  // Present one byte and hold it until a cycle with busy low has passed.
  task automatic drive(input logic pv, input logic [7:0] d);
    int n = 0;
    logic b;
    bus.pkt_valid = pv;
    bus.data_in   = d;
    do begin
      #1 b = bus.busy;
      @(negedge clock);
      n++;
    end while (b && n < 300);
    if (b) chk("drive_timeout", 1, 0);
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input int n, input logic [7:0] par);
    drive(1'b1, hdr);
    err_at_lfd = bus.err;
    for (int i = 0; i < n; i++) drive(1'b1, pay[i]);
    drive(1'b0, par);
    bus.pkt_valid = 1'b0;
    bus.data_in   = 8'h00;
  endtask

  task automatic finish_pkt(input string nm, input logic exp_err);
    @(negedge clock);
    chk({nm, "_err"}, bus.err, exp_err);
    chk({nm, "_idle"}, bus.busy, 1'b0);
  endtask

  task automatic wait_writes(input int target);
    for (int k = 0; k < 200 && wr_cnt < target; k++) begin
      @(negedge clock);
      #3;
    end
    if (wr_cnt < target) chk("wait_writes_timeout", wr_cnt, target);
  endtask

  // Timer model: pulse whenever the current idle run length is a multiple of TIMEOUT.
  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (reset || bus.fifo_empty[i] || bus.read_enb[i]) begin
        run[i]    <= 0;
        exp_sr[i] <= 1'b0;
      end else begin
        run[i]    <= run[i] + 1;
        exp_sr[i] <= ((run[i] + 1) % TIMEOUT) == 0;
      end
    end
  end

  // Per-cycle compare of write strobes/data and soft_reset against the models.
  always @(negedge clock) begin
    logic [10:0] e, g;
    #2;
    if (!reset) begin
      if (bus.write_enb != 3'b000) begin
        wr_cnt++;
        g = {(bus.write_enb[0] ? 2'd0 : bus.write_enb[1] ? 2'd1 : 2'd2), bus.lfd_state, bus.fifo_din};
        if (!$onehot(bus.write_enb)) chk("write_onehot", bus.write_enb, 0);
        else if (exp_q.size() == 0)  chk("unexpected_write", g, 0);
        else begin
          e = exp_q.pop_front();
          chk("write_byte", g, e);
        end
      end else if (bus.lfd_state) begin
        chk("lfd_without_write", 1, 0);
      end
      chk("soft_reset", bus.soft_reset, exp_sr);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, first, cnt;
    logic [7:0] p;
    reset = 1'b1;
    bus.pkt_valid = 1'b0; bus.data_in = 8'h00;
    bus.fifo_full = 3'b000; bus.fifo_empty = 3'b111; bus.read_enb = 3'b000;
    repeat (3) @(negedge clock);
    chk("rst_err", bus.err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wen", bus.write_enb, 0);
    chk("rst_lfd", bus.lfd_state, 0);
    chk("rst_sr", bus.soft_reset, 0);
    reset = 1'b0;
    @(negedge clock);

    // 1: clean packet to FIFO 1
    set_pay(8'h11, 8'h22, 8'h33, 8'h00, 8'h00);
    base = wr_cnt;
    expect_pkt(8'h0D, 3, 8'h0D, 5);
    send_pkt(8'h0D, 3, 8'h0D);
    finish_pkt("t1", pkt_err(8'h0D, 3, 8'h0D));
    chk("t1_writes", wr_cnt - base, 5);
    chk("t1_err_lit", bus.err, 0);

    // 2: bad parity, then a good header clears err
    base = wr_cnt;
    expect_pkt(8'h0D, 3, 8'h00, 5);
    send_pkt(8'h0D, 3, 8'h00);
    finish_pkt("t2", pkt_err(8'h0D, 3, 8'h00));
    chk("t2_err_lit", bus.err, 1);
    chk("t2_writes", wr_cnt - base, 5);
    set_pay(8'h5A, 8'h00, 8'h00, 8'h00, 8'h00);
    expect_pkt(8'h04, 1, 8'h5E, 3);
    send_pkt(8'h04, 1, 8'h5E);
    chk("t2_err_cleared_by_hdr", err_at_lfd, 0);
    finish_pkt("t2b", 1'b0);

    // length mismatch: header says 3, only 2 payload bytes
    set_pay(8'h11, 8'h22, 8'h00, 8'h00, 8'h00);
    expect_pkt(8'h0D, 2, 8'h3E, 4);
    send_pkt(8'h0D, 2, 8'h3E);
    finish_pkt("len_mis", 1'b1);

    // 3: four-cycle full stall on FIFO 1
    set_pay(8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
    p = calc_par(8'h15, 5);
    base = wr_cnt;
    expect_pkt(8'h15, 5, p, 7);
    fork
      send_pkt(8'h15, 5, p);
      begin
        wait_writes(base + 2);
        @(negedge clock);
        bus.fifo_full[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
          #1 chk("t3_stall", {bus.busy, bus.write_enb}, 4'b1000);
          @(negedge clock);
        end
        bus.fifo_full[1] = 1'b0;
      end
    join
    finish_pkt("t3", 1'b0);
    chk("t3_writes", wr_cnt - base, 7);

    // 4: address 3 dropped, len 0 dropped, then a new header is accepted
    set_pay(8'h01, 8'h02, 8'h00, 8'h00, 8'h00);
    base = wr_cnt;
    send_pkt(8'h0F, 2, 8'h00);
    finish_pkt("t4_addr3", 1'b1);
    send_pkt(8'h01, 0, 8'h01);
    finish_pkt("t4_len0", 1'b1);
    chk("t4_no_writes", wr_cnt - base, 0);
    set_pay(8'hC3, 8'h3C, 8'h00, 8'h00, 8'h00);
    expect_pkt(8'h0A, 2, 8'hF5, 4);
    send_pkt(8'h0A, 2, 8'hF5);
    chk("t4_err_cleared_by_hdr", err_at_lfd, 0);
    finish_pkt("t4_good", 1'b0);

    // WAIT: target FIFO not empty at header time
    set_pay(8'h77, 8'h88, 8'h00, 8'h00, 8'h00);
    p = calc_par(8'h08, 2);
    base = wr_cnt;
    expect_pkt(8'h08, 2, p, 4);
    bus.fifo_empty[0] = 1'b0;
    fork
      send_pkt(8'h08, 2, p);
      begin
        repeat (5) @(negedge clock);
        chk("wait_no_write", wr_cnt - base, 0);
        chk("wait_busy", bus.busy, 1);
        bus.fifo_empty[0] = 1'b1;
      end
    join
    finish_pkt("wait", 1'b0);

    // 5: soft_reset timing on FIFO 2
    first = -1; cnt = 0;
    bus.fifo_empty[2] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock); #3;
      if (bus.soft_reset[2]) begin cnt++; if (first < 0) first = k; end
    end
    chk("t5_first_pulse", first, 30);
    chk("t5_pulse_count", cnt, 1);
    bus.fifo_empty[2] = 1'b1;
    @(negedge clock);
    bus.fifo_empty[2] = 1'b0;
    first = -1; cnt = 0;
    for (int k = 1; k <= 55; k++) begin
      @(negedge clock); #3;
      if (bus.soft_reset[2]) begin cnt++; if (first < 0) first = k; end
      if (k == 19) bus.read_enb[2] = 1'b1;
      if (k == 20) bus.read_enb[2] = 1'b0;
    end
    chk("t5_restart_pulse", first, 50);
    chk("t5_restart_count", cnt, 1);
    bus.fifo_empty[2] = 1'b1;
    @(negedge clock);

    // 6: FIFO 0 full and unread mid-packet -> timeout abort
    set_pay(8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00);
    p = calc_par(8'h10, 4);
    base = wr_cnt;
    expect_pkt(8'h10, 4, p, 3);
    fork
      send_pkt(8'h10, 4, p);
      begin
        wait_writes(base + 1);
        @(negedge clock);
        bus.fifo_empty[0] = 1'b0;
        wait_writes(base + 3);
        @(negedge clock);
        bus.fifo_full[0] = 1'b1;
      end
    join
    @(negedge clock);
    chk("t6_err", bus.err, 1);
    chk("t6_writes", wr_cnt - base, 3);
    bus.fifo_full[0] = 1'b0;
    bus.fifo_empty[0] = 1'b1;
    repeat (2) @(negedge clock);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/router_ctrl.md
Name: router_ctrl

Overview:
Ingress controller for the 1x3 router. It decodes each incoming packet header, steers header, payload and parity bytes into one of three output FIFOs, and stalls the sender while the target FIFO is busy or full. It also checks payload length and parity. Per-output timers issue soft_reset to any FIFO whose data sits unread too long. It sits between the source port and the three router FIFOs.

Parameters:
TIMEOUT, 30, consecutive idle cycles (FIFO non-empty, read_enb low) before soft_reset fires; range 2..31
WIDTH, 8, packet byte width

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
pkt_valid  input  1  high during header and payload bytes; low on the parity byte cycle
data_in  input  8  packet byte; header = {len[7:2], addr[1:0]}
fifo_full  input  3  full flag of FIFO 0..2
fifo_empty  input  3  empty flag of FIFO 0..2
read_enb  input  3  downstream read strobes of FIFO 0..2
write_enb  output  3  one-hot write strobe to target FIFO (combinational)
fifo_din  output  8  byte presented to FIFOs (combinational)
lfd_state  output  1  high while the header byte is written
busy  output  1  sender must hold data_in/pkt_valid unchanged while high
err  output  1  registered; packet error flag
soft_reset  output  3  one-cycle pulse per FIFO on timeout

Behaviour:
- Reset: state=DECODE, addr=0, parity=0, byte_cnt=0, hdr_len=0, err=0, soft_reset=0, timers=0. Reset mid-packet aborts the packet.
- Combinational outputs: write_enb=0, busy=0, lfd_state=0, fifo_din=data_in, except as listed per state.
- DECODE (busy=0):
  - pkt_valid with addr!=3 and len!=0: latch addr, hdr_len, hold_reg<=data_in, err<=0. Next state is LFD if fifo_empty[addr], else WAIT.
  - pkt_valid with addr==3 or len==0: err<=1, next DROP.
- WAIT: busy=1. Go to LFD when fifo_empty[addr]=1.
- LFD:
  - busy=1, lfd_state=1, write_enb[addr]=1, fifo_din=hold_reg.
  - parity<=hold_reg, byte_cnt<=0, next LOAD.
  - Header always written, since the FIFO is empty.
- LOAD:
  - busy=fifo_full[addr].
  - If full: no write; stay in LOAD.
  - If not full and pkt_valid=1: write_enb[addr]=1, parity<=parity^data_in, byte_cnt<=byte_cnt+1 (saturates at 63).
  - If not full and pkt_valid=0: write parity byte, rx_par<=data_in, next CHECK.
- CHECK: busy=1. err<=(rx_par!=parity) or (byte_cnt!=hdr_len). Next DECODE.
- DROP: busy=0, no writes. Next DECODE on the first cycle with pkt_valid=0 (that cycle is the parity byte, discarded).
- Abort: soft_reset[addr] asserted in WAIT or LOAD sends the FSM to DROP with err<=1. If pkt_valid=0 in that same cycle, go straight to DECODE.
- Timer i (5 bit):
  - Cleared when fifo_empty[i]=1 or read_enb[i]=1.
  - Otherwise increments each cycle.
  - On reaching TIMEOUT-1, soft_reset[i]<=1 for exactly one cycle and the timer clears.
  - Timers run independently of the FSM. Simultaneous timeouts on several outputs pulse together.
- err holds its value until the next valid header is accepted in DECODE.

Test Plan:
1. Header 0x0D (len 3, addr 1), payload 0x11,0x22,0x33, parity 0x0D^0x11^0x22^0x33=0x0D; all FIFOs empty -> write_enb=3'b010 for 5 cycles, lfd_state on first only, err=0, FSM back in DECODE 6 cycles after header.
2. Same packet with parity 0x00 -> identical writes, err=1 the cycle after CHECK; next valid header clears err.
3. fifo_full[1] asserted for 4 cycles mid-payload -> busy=1 and write_enb=0 for exactly those 4 cycles; no byte lost or duplicated; err=0.
4. Header addr=3 (0x0F) -> no write_enb, err=1, payload ignored until pkt_valid low, then DECODE accepts a new header.
5. fifo_empty[2]=0, read_enb[2]=0 held -> soft_reset[2] pulses on cycle 30 only; one read_enb[2] pulse at cycle 20 restarts the count.
6. FIFO 0 full and unread during LOAD -> soft_reset[0] at timeout, FSM enters DROP, err=1, remaining bytes not written.
